// File: rtl/msx_io_cycle_gen_if.sv
// Bundles the command/response handshake and the MSX slot I/O bus of msx_io_cycle_gen.
// Ports: cmd_* request (valid/ready), rsp_* one-cycle completion, slot_* cartridge bus,
//        cpu_ff_slot_data/cpu_drive_en toward the slot-data bridge.
// master = the cycle generator (drives slot strobes and responses); slave = driver/cartridge side.
interface msx_io_cycle_gen_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       slot_wait;
  logic [7:0] slot_d_in;
  logic [7:0] slot_a;
  logic       slot_iorq_n;
  logic       slot_rd_n;
  logic       slot_wr_n;
  logic [7:0] cpu_ff_slot_data;
  logic       cpu_drive_en;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, slot_wait, slot_d_in,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           slot_a, slot_iorq_n, slot_rd_n, slot_wr_n, cpu_ff_slot_data, cpu_drive_en
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, slot_wait, slot_d_in,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           slot_a, slot_iorq_n, slot_rd_n, slot_wr_n, cpu_ff_slot_data, cpu_drive_en
  );
endinterface

// File: rtl/msx_io_cycle_gen.sv
// Purpose: turns single I/O commands into Z80-style MSX slot I/O cycles (SETUP/STROBE/HOLD).
// Latency: accept -> rsp_valid after S+P+W+H+1 cycles (W = slot_wait cycles in STROBE).
// Backpressure: cmd_ready high only in IDLE; slot_wait stretches STROBE.
// Ports: clk, reset (sync, active-high); bus (msx_io_cycle_gen_if.master) carries cmd_*, rsp_*,
//        slot_a/slot_iorq_n/slot_rd_n/slot_wr_n, slot_wait, slot_d_in, cpu_ff_slot_data, cpu_drive_en.
// Option: define IO_CYCLE_TIMEOUT_EN to abort STROBE after WAIT_TIMEOUT_CYCLES consecutive waits
//         (completion then reports rsp_timeout=1, rsp_rdata=0xFF); otherwise waits are unbounded.
module msx_io_cycle_gen #(
  parameter int unsigned SETUP_CYCLES        = 1,
  parameter int unsigned STROBE_CYCLES       = 2,
  parameter int unsigned HOLD_CYCLES         = 1,
  parameter int unsigned WAIT_TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  msx_io_cycle_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] slot_a_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       write_q;
  logic       iorq_n_q;
  logic       rd_n_q;
  logic       wr_n_q;
  logic       drive_q;
  logic       rsp_valid_q;
  logic       accept;
  logic       wait_expire;

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef IO_CYCLE_TIMEOUT_EN
  logic [7:0] wcnt_q;
  logic       timed_out_q;
  logic       rsp_timeout_q;
  // Abort on the cycle that would make the wait count reach the limit.
  assign wait_expire     = bus.slot_wait && (wcnt_q == 8'(WAIT_TIMEOUT_CYCLES - 1));
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^8'(WAIT_TIMEOUT_CYCLES);
  assign wait_expire          = 1'b0;
  assign bus.rsp_timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd1;
      slot_a_q    <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      write_q     <= 1'b0;
      iorq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef IO_CYCLE_TIMEOUT_EN
      wcnt_q        <= 8'h00;
      timed_out_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef IO_CYCLE_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= SETUP;
            cnt_q    <= 8'(SETUP_CYCLES);
            slot_a_q <= bus.cmd_addr;
            write_q  <= bus.cmd_write;
            if (bus.cmd_write) begin
              wdata_q <= bus.cmd_wdata;
              drive_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_q == 8'd1) begin
            state_q  <= STROBE;
            cnt_q    <= 8'(STROBE_CYCLES);
            iorq_n_q <= 1'b0;
            wr_n_q   <= !write_q;
            rd_n_q   <= write_q;
`ifdef IO_CYCLE_TIMEOUT_EN
            wcnt_q      <= 8'h00;
            timed_out_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        STROBE: begin
`ifdef IO_CYCLE_TIMEOUT_EN
          if (bus.slot_wait) wcnt_q <= wcnt_q + 8'd1;
`endif
          if (wait_expire) begin
            state_q  <= HOLD;
            cnt_q    <= 8'(HOLD_CYCLES);
            iorq_n_q <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rdata_q  <= 8'hFF;
`ifdef IO_CYCLE_TIMEOUT_EN
            timed_out_q <= 1'b1;
`endif
          end else if (!bus.slot_wait) begin
            // Counter only advances on wait-free cycles, so P is a minimum.
            if (cnt_q == 8'd1) begin
              state_q  <= HOLD;
              cnt_q    <= 8'(HOLD_CYCLES);
              iorq_n_q <= 1'b1;
              rd_n_q   <= 1'b1;
              wr_n_q   <= 1'b1;
              if (!write_q) rdata_q <= bus.slot_d_in;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        HOLD: begin
          if (cnt_q == 8'd1) begin
            state_q     <= IDLE;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
`ifdef IO_CYCLE_TIMEOUT_EN
            rsp_timeout_q <= timed_out_q;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.slot_a           = slot_a_q;
  assign bus.cpu_ff_slot_data = wdata_q;
  assign bus.cpu_drive_en     = drive_q;
  assign bus.slot_iorq_n      = iorq_n_q;
  assign bus.slot_rd_n        = rd_n_q;
  assign bus.slot_wr_n        = wr_n_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_rdata        = rdata_q;

endmodule

// File: tb/tb_msx_io_cycle_gen.sv
module tb_msx_io_cycle_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  msx_io_cycle_gen_if bus ();

  msx_io_cycle_gen #(
    .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1), .WAIT_TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       timeout;
    int         rsp_cyc;
    int         iorq_lo;
    int         wr_lo;
    int         rd_lo;
    int         drv_hi;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   wait_budget = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Cartridge wait model: asserts slot_wait on the next wait_budget STROBE cycles.
  initial begin
    bus.slot_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.slot_iorq_n && wait_budget > 0) begin
        bus.slot_wait = 1'b1;
        wait_budget--;
      end else begin
        bus.slot_wait = 1'b0;
      end
    end
  end

  // Monitor: accumulates strobe/drive activity per command, checks on rsp_valid.
  initial begin
    int   n_iorq, n_wr, n_rd, n_drv, addr_bad, data_bad;
    exp_t e;
    n_iorq = 0; n_wr = 0; n_rd = 0; n_drv = 0; addr_bad = 0; data_bad = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready && !bus.rsp_valid) begin
        n_iorq = 0; n_wr = 0; n_rd = 0; n_drv = 0; addr_bad = 0; data_bad = 0;
      end else begin
        if (!bus.slot_iorq_n) begin
          n_iorq++;
          if (sb.size() > 0 && bus.slot_a !== sb[0].addr) addr_bad++;
        end
        if (!bus.slot_wr_n) n_wr++;
        if (!bus.slot_rd_n) n_rd++;
        if (bus.cpu_drive_en) begin
          n_drv++;
          if (sb.size() > 0 && bus.cpu_ff_slot_data !== sb[0].wdata) data_bad++;
        end
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_timeout", bus.rsp_timeout, e.timeout);
          chk("rsp_cycle", cyc, e.rsp_cyc);
          chk("iorq_low_cycles", n_iorq, e.iorq_lo);
          chk("wr_low_cycles", n_wr, e.wr_lo);
          chk("rd_low_cycles", n_rd, e.rd_lo);
          chk("drive_cycles", n_drv, e.drv_hi);
          chk("slot_a_stable", addr_bad, 0);
          chk("wdata_stable", data_bad, 0);
        end
        n_iorq = 0; n_wr = 0; n_rd = 0; n_drv = 0; addr_bad = 0; data_bad = 0;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Expected response for S=1, P=2, H=1 with `waits` wait cycles (or timeout after 4).
  task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd_exp, input int waits, input bit tmo,
                          input int acc);
    exp_t e;
    int   lo;
    lo = tmo ? 4 : 2 + waits;
    e.addr    = a;
    e.wdata   = d;
    e.rdata   = rd_exp;
    e.timeout = tmo;
    e.rsp_cyc = acc + 1 + lo + 1 + 1;
    e.iorq_lo = lo;
    e.wr_lo   = wr ? lo : 0;
    e.rd_lo   = wr ? 0 : lo;
    e.drv_hi  = wr ? lo + 2 : 0;
    sb.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rd_exp, input int waits, input bit tmo,
                       input bit track);
    bit ok;
    @(negedge clk);
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wr ? d : 8'h00;
    bus.slot_d_in = wr ? 8'hEE : d;
    bus.cmd_valid = 1'b1;
    wait_budget   = waits;
    wait_ready(ok);
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (track) push_exp(wr, a, d, rd_exp, waits, tmo, cyc);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      chk("rsp_missing", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int n1, n2;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.slot_d_in = 8'h00;

    // Reset values after the first edge with reset high.
    @(posedge clk);
    #1;
    chk("rst_iorq_n", bus.slot_iorq_n, 1'b1);
    chk("rst_rd_n", bus.slot_rd_n, 1'b1);
    chk("rst_wr_n", bus.slot_wr_n, 1'b1);
    chk("rst_slot_a", bus.slot_a, 8'h00);
    chk("rst_wdata", bus.cpu_ff_slot_data, 8'h00);
    chk("rst_drive", bus.cpu_drive_en, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_after_reset", bus.cmd_ready, 1'b1);

    // Write 0x5A to port 0x99; rdata keeps its reset value.
    issue(1'b1, 8'h99, 8'h5A, 8'h00, 0, 1'b0, 1'b1);
    drain();
    // Read port 0x98.
    issue(1'b0, 8'h98, 8'hA5, 8'hA5, 0, 1'b0, 1'b1);
    drain();
    // Read with 3 wait cycles in STROBE.
    issue(1'b0, 8'h3C, 8'hC3, 8'hC3, 3, 1'b0, 1'b1);
    drain();

    // Back-to-back writes with cmd_valid held high.
    @(negedge clk);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h20;
    bus.cmd_wdata = 8'h01;
    bus.cmd_valid = 1'b1;
    n1 = 0;
    n2 = 0;
    wait_ready(ok);
    if (ok) begin
      n1 = cyc;
      push_exp(1'b1, 8'h20, 8'h01, 8'hC3, 0, 1'b0, n1);
      @(posedge clk);
      #1;
      bus.cmd_addr  = 8'h21;
      bus.cmd_wdata = 8'h02;
      @(negedge clk);
      wait_ready(ok);
      if (ok) begin
        n2 = cyc;
        push_exp(1'b1, 8'h21, 8'h02, 8'hC3, 0, 1'b0, n2);
        @(posedge clk);
        #1;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_period", n2 - n1, 5);
    drain();

    // Reset asserted during STROBE of a write.
    issue(1'b1, 8'h55, 8'h11, 8'h00, 0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.slot_iorq_n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_strobe", ok, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_iorq_n", bus.slot_iorq_n, 1'b1);
    chk("abort_wr_n", bus.slot_wr_n, 1'b1);
    chk("abort_rd_n", bus.slot_rd_n, 1'b1);
    chk("abort_drive", bus.cpu_drive_en, 1'b0);
    chk("abort_slot_a", bus.slot_a, 8'h00);
    chk("abort_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("abort_no_rsp", bus.rsp_valid, 1'b0);
    reset = 1'b0;
    #1 chk("abort_ready_after", bus.cmd_ready, 1'b1);
    repeat (8) @(negedge clk);

    // Read after reset.
    issue(1'b0, 8'h10, 8'h77, 8'h77, 0, 1'b0, 1'b1);
    drain();

`ifdef IO_CYCLE_TIMEOUT_EN
    // Wait stuck high: aborted after 4 wait cycles.
    issue(1'b0, 8'h0F, 8'h12, 8'hFF, 1000, 1'b1, 1'b1);
    drain();
    wait_budget = 0;
    repeat (2) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
